// File: rtl/decoder.sv
// rtl/decoder.sv - binary-to-one-hot decoder with enable and a registered copy
module decoder #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    input  logic             en,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic             en_q
);

    logic [OUT_W-1:0] out_d;
    logic             en_d;

    // Pure decode: no clock or reset in this path.
    always_comb begin
        out_d = '0;
        if (en) begin
            out_d[in] = 1'b1;
        end
        en_d = en;
    end

    assign out = out_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            en_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            en_q  <= en_d;
        end
    end

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - scoreboard bench for decoder with a random reference model
module tb_decoder;

    localparam int IN_W  = 2;
    localparam int OUT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [IN_W-1:0]  in_s;
    logic             en_s;
    logic [OUT_W-1:0] out_s;
    logic [OUT_W-1:0] out_q_s;
    logic             en_q_s;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [OUT_W-1:0] o;
        logic             e;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;

    decoder #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_s),
        .en    (en_s),
        .out   (out_s),
        .out_q (out_q_s),
        .en_q  (en_q_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: enabled output is the power of two selected by the index.
    function automatic logic [OUT_W-1:0] ref_out(int idx, bit e);
        int v;
        logic [31:0] w;
        v = e ? (2 ** idx) : 0;
        w = v;
        return w[OUT_W-1:0];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(int i, bit e);
        @(negedge clk);
        in_s = i[IN_W-1:0];
        en_s = e;
        #1;
        check("out_comb", 32'(out_s), 32'(ref_out(i, e)));
        if (rst_n) sb_q.push_back('{ref_out(i, e), e});
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && sb_q.size() > 0) begin
            mon_x = sb_q.pop_front();
            check("out_q", 32'(out_q_s), 32'(mon_x.o));
            check("en_q", 32'(en_q_s), 32'(mon_x.e));
            check("out_q_onehot0", 32'($onehot0(out_q_s)), 32'd1);
        end
    end

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("rst_async_out_q", 32'(out_q_s), 32'd0);
        check("rst_async_en_q", 32'(en_q_s), 32'd0);
        check("rst_out_follows", 32'(out_s), 32'(ref_out(int'(in_s), en_s)));
        @(posedge clk);
        #1;
        check("rst_hold_out_q", 32'(out_q_s), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back('{ref_out(int'(in_s), en_s), en_s});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_s  = '0;
        en_s  = 1'b0;
        #1;
        check("reset_out", 32'(out_s), 32'd0);
        check("reset_out_q", 32'(out_q_s), 32'd0);
        check("reset_en_q", 32'(en_q_s), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_q_clk", 32'(out_q_s), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back('{ref_out(0, 1'b0), 1'b0});

        apply(3, 1'b1);
        apply(1, 1'b1);
        apply(3, 1'b0);
        for (int i = 0; i < OUT_W; i++) apply(i, 1'b1);

        // Reset with out_q holding the top bit.
        apply(3, 1'b1);
        @(posedge clk);
        mid_reset();

        for (int k = 0; k < 200; k++) begin
            apply(int'($urandom_range(0, OUT_W - 1)), ($urandom_range(0, 3) != 0));
            if (k == 120) mid_reset();
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
